melody_sequencer: RTL and testbench

- Reader/player for the synchronous melody ROM.
- Walks ROM addresses in order and decodes each 16-bit entry into pitch and duration.
- Holds each note for its decoded length, with an articulation gap between notes.
- Drives the tone/FM generator with a signed semitone offset from A4 plus a tone-enable. Supports one-shot and looped playback.

---
 rtl/melody_sequencer.sv | 179 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Melody ROM player: fetches 16-bit entries in address order, decodes pitch and
// duration, and drives a tone generator with per-note articulation gaps.
module melody_sequencer #(
   parameter int unsigned ADDR_WIDTH     = 7,
   parameter int unsigned MELODY_LEN     = 16,
   parameter int unsigned TICKS_PER_16TH = 1000000,
   parameter int unsigned GAP_TICKS      = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  loop,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [15:0]           rom_data,
   output logic [7:0]            note_pitch,
   output logic                  tone_on,
   output logic                  note_start,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned PRESC_W = (TICKS_PER_16TH > 1) ? $clog2(TICKS_PER_16TH) : 1;
   localparam int unsigned GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [PRESC_W-1:0]    PRESC_LOAD = PRESC_W'(TICKS_PER_16TH - 1);
   localparam logic [GAP_W-1:0]      GAP_LOAD   = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MELODY_LEN - 1);
   localparam logic [7:0]            REST_CODE  = 8'h80;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StPlay,
      StGap,
      StAdvance,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              pitch_q, pitch_d;
   logic                    rest_q, rest_d;
   logic [4:0]              units_q, units_d;
   logic [PRESC_W-1:0]      presc_q, presc_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic                    start_q, start_d;
   logic                    go_idle;

   // Articulation bits of the ROM word carry no meaning for playback.
   logic unused_rom_bits;
   assign unused_rom_bits = ^rom_data[7:6];

   function automatic logic [4:0] dur_units(input logic [5:0] dur);
      logic [4:0] u;
      case (dur)
         6'd0:    u = 5'd1;
         6'd1:    u = 5'd2;
         6'd2:    u = 5'd4;
         6'd3:    u = 5'd8;
         6'd4:    u = 5'd16;
         6'd5:    u = 5'd3;
         default: u = 5'd1;
      endcase
      return u;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pitch_d = pitch_q;
      rest_d  = rest_q;
      units_d = units_q;
      presc_d = presc_q;
      gap_d   = gap_q;
      start_d = 1'b0;
      go_idle = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StFetch;
         end
         StFetch: begin
            state_d = StLatch;
         end
         StLatch: begin
            rest_d = (rom_data[15:8] == REST_CODE);
            if (rom_data[15:8] != REST_CODE) pitch_d = rom_data[15:8];
            units_d = dur_units(rom_data[5:0]);
            presc_d = PRESC_LOAD;
            start_d = 1'b1;
            state_d = StPlay;
         end
         StPlay: begin
            if (presc_q == '0) begin
               if (units_q == 5'd1) begin
                  units_d = '0;
                  gap_d   = GAP_LOAD;
                  state_d = (GAP_TICKS == 0) ? StAdvance : StGap;
               end else begin
                  units_d = units_q - 5'd1;
                  presc_d = PRESC_LOAD;
               end
            end else begin
               presc_d = presc_q - PRESC_W'(1);
            end
         end
         StGap: begin
            if (gap_q == '0) begin
               state_d = StAdvance;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         StAdvance: begin
            if (addr_q == LAST_ADDR) begin
               if (loop) begin
                  addr_d  = '0;
                  state_d = StFetch;
               end else begin
                  state_d = StDone;
               end
            end else begin
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = StFetch;
            end
         end
         StDone: begin
            if (!enable) go_idle = 1'b1;
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      // Dropping enable mid-melody discards the note entirely; abort beats expiry.
      if (!enable && state_q != StIdle && state_q != StDone) go_idle = 1'b1;

      if (go_idle) begin
         state_d = StIdle;
         addr_d  = '0;
         pitch_d = '0;
         rest_d  = 1'b0;
         units_d = '0;
         presc_d = '0;
         gap_d   = '0;
         start_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         pitch_q <= '0;
         rest_q  <= 1'b0;
         units_q <= '0;
         presc_q <= '0;
         gap_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pitch_q <= pitch_d;
         rest_q  <= rest_d;
         units_q <= units_d;
         presc_q <= presc_d;
         gap_q   <= gap_d;
         start_q <= start_d;
      end
   end

   assign rom_addr   = addr_q;
   assign note_pitch = pitch_q;
   assign tone_on    = (state_q == StPlay) && !rest_q;
   assign note_start = start_q;
   assign busy       = (state_q != StIdle) && (state_q != StDone);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: three configurations share one melody
// table; expected notes are queued per instance and retired on note_start.
module tb_melody_sequencer;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] pitch;
      logic       tone;
      int         tone_len;
      int         period;
   } note_t;

   function automatic int unsigned tps_of(input int d);
      return (d == 2) ? 1 : 4;
   endfunction
   function automatic int unsigned gap_of(input int d);
      return (d == 1) ? 0 : 2;
   endfunction
   function automatic int unsigned len_of(input int d);
      return (d == 1) ? 17 : 16;
   endfunction
   function automatic int units_of(input logic [5:0] dur);
      case (dur)
         6'd0: return 1;
         6'd1: return 2;
         6'd2: return 4;
         6'd3: return 8;
         6'd4: return 16;
         6'd5: return 3;
         default: return 1;
      endcase
   endfunction

   logic        clk;
   logic [2:0]  rst_n, enable, loop, tone_on, note_start, busy, done;
   logic [6:0]  rom_addr   [3];
   logic [15:0] rom_data   [3];
   logic [7:0]  note_pitch [3];
   logic [15:0] rom_words  [128];
   logic [15:0] song       [17];

   note_t exp_q [3][$];
   note_t cur       [3];
   int    tone_run  [3];
   int    since     [3];
   int    done_seen [3];
   logic  have_prev [3];
   logic  have_cur  [3];
   int    n_tests, n_fail, cycles;
   logic [7:0] lp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      melody_sequencer #(
         .ADDR_WIDTH     (7),
         .MELODY_LEN     (len_of(g)),
         .TICKS_PER_16TH (tps_of(g)),
         .GAP_TICKS      (gap_of(g))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n[g]),
         .enable     (enable[g]),
         .loop       (loop[g]),
         .rom_addr   (rom_addr[g]),
         .rom_data   (rom_data[g]),
         .note_pitch (note_pitch[g]),
         .tone_on    (tone_on[g]),
         .note_start (note_start[g]),
         .busy       (busy[g]),
         .done       (done[g])
      );
      always @(posedge clk) rom_data[g] <= rom_words[rom_addr[g]];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic monitor(input int d);
      if (done[d] === 1'b1) done_seen[d]++;
      if (tone_on[d] === 1'b1) begin
         tone_run[d]++;
      end else begin
         if (tone_run[d] != 0 && busy[d] === 1'b1 && have_cur[d])
            check_eq($sformatf("d%0d_tone_len", d), tone_run[d], cur[d].tone_len);
         tone_run[d] = 0;
      end
      since[d]++;
      if (note_start[d] === 1'b1) begin
         if (have_prev[d]) check_eq($sformatf("d%0d_period", d), since[d], cur[d].period);
         check_eq($sformatf("d%0d_note_avail", d), exp_q[d].size() != 0, 1);
         if (exp_q[d].size() != 0) begin
            cur[d]      = exp_q[d].pop_front();
            have_cur[d] = 1'b1;
            check_eq($sformatf("d%0d_addr@%0d", d, cur[d].addr), rom_addr[d], cur[d].addr);
            check_eq($sformatf("d%0d_pitch@%0d", d, cur[d].addr), note_pitch[d], cur[d].pitch);
            check_eq($sformatf("d%0d_tone@%0d", d, cur[d].addr), tone_on[d], cur[d].tone);
         end
         since[d]     = 0;
         have_prev[d] = 1'b1;
      end
      if (busy[d] !== 1'b1) have_prev[d] = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      cycles++;
      if (cycles > 50000) begin
         $display("FAIL watchdog: got %0d cycles, expected under 50000", cycles);
         $fatal(1, "bench timeout");
      end
      for (int d = 0; d < 3; d++) monitor(d);
   endtask

   task automatic push_run(input int d, input int first, input int last, inout logic [7:0] p);
      for (int a = first; a <= last; a++) begin
         note_t n;
         logic [15:0] w;
         w          = song[a];
         n.addr     = 7'(a);
         n.tone     = (w[15:8] != 8'h80);
         if (n.tone) p = w[15:8];
         n.pitch    = p;
         n.tone_len = units_of(w[5:0]) * int'(tps_of(d));
         n.period   = n.tone_len + int'(gap_of(d)) + 3;
         exp_q[d].push_back(n);
      end
   endtask

   task automatic drain(input int d, input int budget);
      int n = 0;
      while (exp_q[d].size() != 0 && n < budget) begin
         step();
         n++;
      end
      check_eq($sformatf("d%0d_drain", d), exp_q[d].size(), 0);
   endtask

   task automatic wait_done(input int d, input int budget);
      int n = 0;
      while (done[d] !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check_eq($sformatf("d%0d_done_wait", d), done[d], 1);
   endtask

   task automatic check_reset(input int d, input string tag);
      check_eq($sformatf("%s_addr", tag), rom_addr[d], 0);
      check_eq($sformatf("%s_pitch", tag), note_pitch[d], 0);
      check_eq($sformatf("%s_tone", tag), tone_on[d], 0);
      check_eq($sformatf("%s_start", tag), note_start[d], 0);
      check_eq($sformatf("%s_busy", tag), busy[d], 0);
      check_eq($sformatf("%s_done", tag), done[d], 0);
   endtask

   initial begin
      int ds;
      n_tests = 0;
      n_fail  = 0;
      cycles  = 0;
      song = '{16'hF701, 16'hF901, 16'hFBC0, 16'hFC03, 16'hFE05, 16'h0001, 16'h0206,
               16'h033F, 16'h8001, 16'h7F04, 16'h8141, 16'hFE01, 16'hFC01, 16'hFB01,
               16'hF901, 16'hF702, 16'h8002};
      for (int i = 0; i < 128; i++) rom_words[i] = (i < 17) ? song[i] : 16'h0000;
      for (int d = 0; d < 3; d++) begin
         tone_run[d]  = 0;
         since[d]     = 0;
         done_seen[d] = 0;
         have_prev[d] = 1'b0;
         have_cur[d]  = 1'b0;
      end
      rst_n  = '0;
      enable = '0;
      loop   = '0;
      repeat (3) step();
      rst_n = '1;
      for (int d = 0; d < 3; d++) check_reset(d, $sformatf("d%0d_rst", d));

      // One-shot playback with first-note timing and the first gap.
      lp = 8'h00;
      push_run(0, 0, 15, lp);
      enable[0] = 1'b1;
      step();
      check_eq("a_fetch_busy", busy[0], 1);
      check_eq("a_fetch_tone", tone_on[0], 0);
      step();
      check_eq("a_latch_tone", tone_on[0], 0);
      step();
      check_eq("a_first_tone", tone_on[0], 1);
      check_eq("a_first_start", note_start[0], 1);
      check_eq("a_first_pitch", note_pitch[0], 8'hF7);
      step();
      check_eq("a_start_pulse", note_start[0], 0);
      repeat (7) step();
      check_eq("a_gap_tone", tone_on[0], 0);
      check_eq("a_gap_busy", busy[0], 1);
      repeat (2) step();
      check_eq("a_adv_addr", rom_addr[0], 0);
      step();
      check_eq("a_next_addr", rom_addr[0], 1);
      drain(0, 2000);
      wait_done(0, 200);
      check_eq("a_done_busy", busy[0], 0);
      check_eq("a_done_addr", rom_addr[0], 15);
      check_eq("a_done_tone", tone_on[0], 0);
      repeat (4) step();
      check_eq("a_hold_done", done[0], 1);
      check_eq("a_hold_addr", rom_addr[0], 15);
      enable[0] = 1'b0;
      step();
      check_eq("a_idle_done", done[0], 0);
      check_eq("a_idle_addr", rom_addr[0], 0);
      check_eq("a_idle_busy", busy[0], 0);

      // Looped playback wraps to entry 0, then abort mid-note of entry 5.
      loop[0] = 1'b1;
      lp = 8'h00;
      push_run(0, 0, 15, lp);
      push_run(0, 0, 0, lp);
      ds = done_seen[0];
      enable[0] = 1'b1;
      drain(0, 2000);
      check_eq("l_no_done", done_seen[0] - ds, 0);
      check_eq("l_busy", busy[0], 1);
      push_run(0, 1, 5, lp);
      drain(0, 1000);
      repeat (2) step();
      enable[0] = 1'b0;
      step();
      check_eq("ab_tone", tone_on[0], 0);
      check_eq("ab_busy", busy[0], 0);
      check_eq("ab_addr", rom_addr[0], 0);
      check_eq("ab_pitch", note_pitch[0], 0);
      loop[0] = 1'b0;
      lp = 8'h00;
      push_run(0, 0, 1, lp);
      enable[0] = 1'b1;
      drain(0, 200);
      enable[0] = 1'b0;
      step();
      check_eq("re_idle", busy[0], 0);

      // No-gap config with a 17th REST entry, looped back to entry 0.
      loop[1] = 1'b1;
      lp = 8'h00;
      push_run(1, 0, 16, lp);
      enable[1] = 1'b1;
      drain(1, 2000);
      check_eq("r_start", note_start[1], 1);
      check_eq("r_pitch", note_pitch[1], 8'hF7);
      check_eq("r_busy", busy[1], 1);
      for (int i = 0; i < 7; i++) begin
         step();
         check_eq($sformatf("r_silent%0d", i), tone_on[1], 0);
      end
      push_run(1, 0, 0, lp);
      drain(1, 100);
      enable[1] = 1'b0;
      step();

      // Single-tick units, then a reset pulse in the middle of an 8-unit note.
      lp = 8'h00;
      push_run(2, 0, 3, lp);
      enable[2] = 1'b1;
      drain(2, 500);
      repeat (2) step();
      check_eq("t_mid_tone", tone_on[2], 1);
      rst_n[2]  = 1'b0;
      enable[2] = 1'b0;
      step();
      check_reset(2, "t_rst");
      rst_n[2] = 1'b1;
      step();
      check_eq("t_after_busy", busy[2], 0);

      for (int d = 0; d < 3; d++) check_eq($sformatf("d%0d_q_left", d), exp_q[d].size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
